sram_uart_dump_tx: RTL

- Transmit-direction counterpart to the UART-to-SRAM loader: streams a contiguous region of the external SRAM (e.g. the decoded RGB image) out over UART.
- Reads 16-bit words through the SRAM controller's read port and sends each one as two 8N1 bytes, high byte first.
- The host-side byte stream is therefore identical to the .sram_d* / RGB file layout.
- Sits beside the UART receiver under the top-level FSM and owns the SRAM port only while Busy.

---
 rtl/sram_dump_pkg.sv | 37 +++
 rtl/uart_tx_byte.sv | 75 +++++++
 rtl/sram_uart_dump_tx.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_dump_pkg.sv
// -----------------------------------------------------------------------------
// sram_dump_pkg
//   Shared definitions for the SRAM-to-UART dump transmitter:
//   - dump_state_t    : FSM state encoding (S_DUMP_*)
//   - UART_FRAME_BITS : bits per 8N1 frame (start + 8 data + stop)
//   - PPM_HEADER      : "P6\n192 144\n255\n" bytes sent first when the
//                       SRAM_DUMP_PPM_HEADER_EN macro is defined
// -----------------------------------------------------------------------------
package sram_dump_pkg;

    typedef enum logic [2:0] {
        S_DUMP_IDLE    = 3'd0,
        S_DUMP_RD_ADDR = 3'd1,
        S_DUMP_RD_WAIT = 3'd2,
        S_DUMP_CAPTURE = 3'd3,
        S_DUMP_TX_HI   = 3'd4,
        S_DUMP_TX_LO   = 3'd5,
        S_DUMP_FINISH  = 3'd6,
        S_DUMP_HEADER  = 3'd7
    } dump_state_t;

    localparam int UART_FRAME_BITS = 10;

    localparam int PPM_HEADER_LEN = 15;

    localparam logic [7:0] PPM_HEADER [PPM_HEADER_LEN] = '{
        8'h50, 8'h36, 8'h0A,                      // "P6\n"
        8'h31, 8'h39, 8'h32, 8'h20,               // "192 "
        8'h31, 8'h34, 8'h34, 8'h0A,               // "144\n"
        8'h32, 8'h35, 8'h35, 8'h0A                // "255\n"
    };

    function automatic logic [7:0] ppm_header_byte(input logic [3:0] idx);
        return PPM_HEADER[idx];
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// -----------------------------------------------------------------------------
// uart_tx_byte
//   8N1 serialiser. One frame = start bit (0), 8 data bits LSB first, stop
//   bit (1); every bit lasts CLKS_PER_BIT cycles.
//
// Ports
//   Clock  in   system clock
//   Reset  in   asynchronous, active-high reset (line returns high at once)
//   Load   in   start a frame with Data; honoured only while Ready=1
//   Data   in   byte to send
//   TX     out  serial line, idles high (driven straight from a flop)
//   Ready  out  high while idle and in the last cycle of a stop bit, so a
//               Load in that cycle chains the next frame with no gap
// -----------------------------------------------------------------------------
module uart_tx_byte
    import sram_dump_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Load,
    input  logic [7:0] Data,
    output logic       TX,
    output logic       Ready
);

    localparam int                CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]        BIT_LAST = 4'(UART_FRAME_BITS - 1);

    // Frame shift register: bit 0 is the line. Ones shift in from the top, so
    // once a frame is finished the line rests high without extra logic.
    logic [UART_FRAME_BITS-1:0] r_frame;
    logic [CNT_W-1:0]           r_clk_cnt;
    logic [3:0]                 r_bit_idx;
    logic                       r_active;

    logic w_bit_end;
    logic w_frame_end;

    assign w_bit_end   = (r_clk_cnt == CNT_LAST);
    assign w_frame_end = r_active && w_bit_end && (r_bit_idx == BIT_LAST);
    assign Ready       = !r_active || w_frame_end;
    assign TX          = r_frame[0];

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_frame   <= '1;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_active  <= 1'b0;
        end else if (Load && Ready) begin
            r_frame   <= {1'b1, Data, 1'b0};
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_active  <= 1'b1;
        end else if (r_active) begin
            if (w_bit_end) begin
                r_clk_cnt <= '0;
                r_frame   <= {1'b1, r_frame[UART_FRAME_BITS-1:1]};
                if (r_bit_idx == BIT_LAST) begin
                    r_active <= 1'b0;
                end else begin
                    r_bit_idx <= r_bit_idx + 4'd1;
                end
            end else begin
                r_clk_cnt <= r_clk_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sram_uart_dump_tx.sv
// -----------------------------------------------------------------------------
// sram_uart_dump_tx
//   Streams Word_count 16-bit SRAM words starting at Base_address out over
//   UART as 8N1 bytes, high byte first. The next word is prefetched while the
//   current low byte is on the line, so frames run back-to-back.
//
//   Optional build macro: SRAM_DUMP_PPM_HEADER_EN
//     When defined, the 15-byte PPM header "P6\n192 144\n255\n" is sent before
//     the data; the first SRAM read overlaps the header frames.
//
// Parameters
//   CLKS_PER_BIT     clock cycles per UART bit
//   SRAM_RD_LATENCY  cycles from SRAM_address valid to SRAM_read_data valid;
//                    must satisfy 1 <= SRAM_RD_LATENCY <= 10*CLKS_PER_BIT-2 so
//                    a prefetch always lands inside one frame
//
// Ports
//   Clock           in   system clock
//   Reset           in   asynchronous, active-high reset
//   Start           in   one-cycle request, honoured only while Busy=0
//   Base_address    in   first SRAM word address (latched on Start)
//   Word_count      in   number of words to send, 0 allowed (latched on Start)
//   SRAM_address    out  read address to the SRAM controller
//   SRAM_we_n       out  tied high, this block only reads
//   SRAM_read_data  in   read data, sampled only at the capture points
//   UART_TX_O       out  serial line, idles high
//   Busy            out  high from the cycle after Start until Done
//   Done            out  one-cycle completion pulse (Busy already low)
// -----------------------------------------------------------------------------
module sram_uart_dump_tx
    import sram_dump_pkg::*;
#(
    parameter int CLKS_PER_BIT    = 434,
    parameter int SRAM_RD_LATENCY = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [17:0] Base_address,
    input  logic [17:0] Word_count,
    output logic [17:0] SRAM_address,
    output logic        SRAM_we_n,
    input  logic [15:0] SRAM_read_data,
    output logic        UART_TX_O,
    output logic        Busy,
    output logic        Done
);

    // Read-latency counter: cleared when a new address is issued and
    // saturating one past the data-valid count, so the "data valid" decode is
    // true for exactly one cycle per read.
    localparam int               LAT_W         = $clog2(SRAM_RD_LATENCY + 2);
    localparam logic [LAT_W-1:0] LAT_WAIT_LAST = LAT_W'(SRAM_RD_LATENCY - 1);
    localparam logic [LAT_W-1:0] LAT_DATA      = LAT_W'(SRAM_RD_LATENCY);
    localparam logic [LAT_W-1:0] LAT_DONE      = LAT_W'(SRAM_RD_LATENCY + 1);

    dump_state_t      r_state;
    dump_state_t      w_next_state;

    logic [17:0]      r_address;
    logic [17:0]      r_words_left;   // words not yet handed to the serialiser
    logic [15:0]      r_word;
    logic [LAT_W-1:0] r_lat_cnt;

    logic             w_data_valid;
    logic             w_start_ok;
    logic             w_addr_base;
    logic             w_addr_inc;
    logic             w_word_cap;
    logic             w_words_dec;
    logic             w_uart_load;
    logic [7:0]       w_uart_data;
    logic             w_uart_ready;

`ifdef SRAM_DUMP_PPM_HEADER_EN
    logic [3:0]       r_hdr_idx;      // index of the next header byte to load
    logic             w_hdr_adv;
`endif

    assign w_data_valid = (r_lat_cnt == LAT_DATA);

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= S_DUMP_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state and datapath controls
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        w_next_state = r_state;
        w_start_ok   = 1'b0;
        w_addr_base  = 1'b0;
        w_addr_inc   = 1'b0;
        w_word_cap   = 1'b0;
        w_words_dec  = 1'b0;
        w_uart_load  = 1'b0;
        w_uart_data  = 8'h00;
`ifdef SRAM_DUMP_PPM_HEADER_EN
        w_hdr_adv    = 1'b0;
`endif

        case (r_state)
            // FINISH lasts one cycle with Busy already low, so a Start arriving
            // there is honoured exactly like one in IDLE.
            S_DUMP_IDLE, S_DUMP_FINISH: begin
                w_next_state = S_DUMP_IDLE;
                if (Start) begin
                    w_start_ok  = 1'b1;
                    // An empty dump never touches the SRAM port.
                    w_addr_base = (Word_count != '0);
`ifdef SRAM_DUMP_PPM_HEADER_EN
                    w_uart_load  = 1'b1;
                    w_uart_data  = ppm_header_byte(4'd0);
                    w_next_state = S_DUMP_HEADER;
`else
                    w_next_state = (Word_count == '0) ? S_DUMP_FINISH : S_DUMP_RD_ADDR;
`endif
                end
            end

            S_DUMP_RD_ADDR: begin
                w_next_state = (SRAM_RD_LATENCY > 1) ? S_DUMP_RD_WAIT : S_DUMP_CAPTURE;
            end

            S_DUMP_RD_WAIT: begin
                if (r_lat_cnt == LAT_WAIT_LAST) begin
                    w_next_state = S_DUMP_CAPTURE;
                end
            end

            // Data is valid this cycle: keep the word and send its high byte
            // straight from the bus so the start bit follows next cycle.
            S_DUMP_CAPTURE: begin
                w_word_cap   = 1'b1;
                w_words_dec  = 1'b1;
                w_uart_load  = 1'b1;
                w_uart_data  = SRAM_read_data[15:8];
                w_next_state = S_DUMP_TX_HI;
            end

            // At the end of the high byte, chain the low byte and, if more
            // words follow, issue the prefetch read for the next one.
            S_DUMP_TX_HI: begin
                if (w_uart_ready) begin
                    w_uart_load  = 1'b1;
                    w_uart_data  = r_word[7:0];
                    w_addr_inc   = (r_words_left != '0);
                    w_next_state = S_DUMP_TX_LO;
                end
            end

            // The low byte has already been copied into the serialiser, so the
            // prefetched word may overwrite r_word mid-frame.
            S_DUMP_TX_LO: begin
                if ((r_words_left != '0) && w_data_valid) begin
                    w_word_cap = 1'b1;
                end
                if (w_uart_ready) begin
                    if (r_words_left != '0) begin
                        w_uart_load  = 1'b1;
                        w_uart_data  = r_word[15:8];
                        w_words_dec  = 1'b1;
                        w_next_state = S_DUMP_TX_HI;
                    end else begin
                        w_next_state = S_DUMP_FINISH;
                    end
                end
            end

`ifdef SRAM_DUMP_PPM_HEADER_EN
            // Header frames; the first word's read runs underneath them.
            S_DUMP_HEADER: begin
                if ((r_words_left != '0) && w_data_valid) begin
                    w_word_cap = 1'b1;
                end
                if (w_uart_ready) begin
                    if (r_hdr_idx != 4'(PPM_HEADER_LEN)) begin
                        w_uart_load = 1'b1;
                        w_uart_data = ppm_header_byte(r_hdr_idx);
                        w_hdr_adv   = 1'b1;
                    end else if (r_words_left != '0) begin
                        w_uart_load  = 1'b1;
                        w_uart_data  = r_word[15:8];
                        w_words_dec  = 1'b1;
                        w_next_state = S_DUMP_TX_HI;
                    end else begin
                        w_next_state = S_DUMP_FINISH;
                    end
                end
            end
`endif

            default: begin
                w_next_state = S_DUMP_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_address    <= '0;
            r_words_left <= '0;
            r_word       <= '0;
            r_lat_cnt    <= '0;
        end else begin
            // 18-bit add wraps 0x3FFFF to 0x00000 on its own.
            if (w_addr_base) begin
                r_address <= Base_address;
            end else if (w_addr_inc) begin
                r_address <= r_address + 18'd1;
            end

            if (w_addr_base || w_addr_inc) begin
                r_lat_cnt <= '0;
            end else if (r_lat_cnt != LAT_DONE) begin
                r_lat_cnt <= r_lat_cnt + LAT_W'(1);
            end

            if (w_start_ok) begin
                r_words_left <= Word_count;
            end else if (w_words_dec) begin
                r_words_left <= r_words_left - 18'd1;
            end

            if (w_word_cap) begin
                r_word <= SRAM_read_data;
            end
        end
    end

`ifdef SRAM_DUMP_PPM_HEADER_EN
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_hdr_idx <= '0;
        end else if (w_start_ok) begin
            r_hdr_idx <= 4'd1;          // byte 0 is loaded with the Start
        end else if (w_hdr_adv) begin
            r_hdr_idx <= r_hdr_idx + 4'd1;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Serialiser
    // -------------------------------------------------------------------------
    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx_byte (
        .Clock (Clock),
        .Reset (Reset),
        .Load  (w_uart_load),
        .Data  (w_uart_data),
        .TX    (UART_TX_O),
        .Ready (w_uart_ready)
    );

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign SRAM_address = r_address;
    assign SRAM_we_n    = 1'b1;
    assign Busy         = (r_state != S_DUMP_IDLE) && (r_state != S_DUMP_FINISH);
    assign Done         = (r_state == S_DUMP_FINISH);

endmodule
